// File: rtl/bch_ibm_solver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bch_ibm_solver                                                |
// | Purpose  : Inversion-free Berlekamp-Massey key-equation solver for the   |
// |            binary BCH decoder. Turns 2t syndromes into the error-locator |
// |            polynomial Lambda(x), its degree L and an uncorrectable flag. |
// |            Codes: (63,51) t=2 GF(2^6), (255,239) t=2 GF(2^8),            |
// |            (1023,983) t=4 GF(2^10).                                      |
// | Ports    : clk, rstn (async, active-low)                                 |
// |            code   [1:0]  1: m=6,t=2  2: m=8,t=2  0/3: m=10,t=4           |
// |            start         one-cycle request, accepted in IDLE only        |
// |            syn    [79:0] S1..S8, 10 bits each, S1 in [9:0]               |
// |            busy          high while a solve is in flight                 |
// |            done          one-cycle result-valid pulse                    |
// |            lambda [49:0] Lambda0..Lambda4, Lambda0 in [9:0]              |
// |            deg    [2:0]  final L                                         |
// |            fail          L > t at completion                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bch_ibm_solver #(
  parameter int M_MAX = 10,
  parameter int T_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [1:0]                   code,
  input  logic                         start,
  input  logic [2*T_MAX*M_MAX-1:0]     syn,
  output logic                         busy,
  output logic                         done,
  output logic [(T_MAX+1)*M_MAX-1:0]   lambda,
  output logic [2:0]                   deg,
  output logic                         fail
);

  localparam int c_ns = 2 * T_MAX;
  localparam int c_nl = T_MAX + 1;
  localparam int c_rw = $clog2(c_ns + 1);
  localparam int c_lw = 3;

  // Internal field selector
  localparam logic [1:0] c_f6  = 2'd0;
  localparam logic [1:0] c_f8  = 2'd1;
  localparam logic [1:0] c_f10 = 2'd2;

  typedef enum logic [1:0] {IDLE, DISC, UPD, DONE} state_t;

  function automatic logic [1:0] fsel_of(input logic [1:0] c);
    case (c)
      2'd1:    fsel_of = c_f6;
      2'd2:    fsel_of = c_f8;
      default: fsel_of = c_f10;
    endcase
  endfunction

  function automatic logic [M_MAX-1:0] mask_of(input logic [1:0] f);
    case (f)
      c_f6:    mask_of = M_MAX'('h03F);
      c_f8:    mask_of = M_MAX'('h0FF);
      default: mask_of = M_MAX'('h3FF);
    endcase
  endfunction

  // Horner-style GF(2^m) product: shift/reduce the accumulator, then add a.
  // Operands are always already masked to m bits.
  function automatic logic [M_MAX-1:0] gf_mul(input logic [M_MAX-1:0] a,
                                              input logic [M_MAX-1:0] b,
                                              input logic [1:0]       f);
    logic [M_MAX-1:0] acc, mask, top, plow;
    mask = mask_of(f);
    top  = mask & ~(mask >> 1);
    case (f)
      c_f6:    plow = M_MAX'('h003);   // x^6+x+1
      c_f8:    plow = M_MAX'('h01D);   // x^8+x^4+x^3+x^2+1
      default: plow = M_MAX'('h009);   // x^10+x^3+1
    endcase
    acc = {M_MAX{1'b0}};
    for (int i = M_MAX - 1; i >= 0; i--) begin
      acc = ((acc << 1) & mask) ^ (((acc & top) != {M_MAX{1'b0}}) ? plow : {M_MAX{1'b0}});
      if (b[i]) acc = acc ^ a;
    end
    return acc;
  endfunction

  state_t            r_state, w_state_next;
  logic [1:0]        r_fsel;
  logic [M_MAX-1:0]  r_syn   [c_ns];
  logic [M_MAX-1:0]  r_lam   [c_nl];
  logic [M_MAX-1:0]  r_b     [c_nl];
  logic [M_MAX-1:0]  r_gamma;
  logic [M_MAX-1:0]  r_delta;
  logic [c_lw-1:0]   r_l;
  logic [c_rw-1:0]   r_r;

  logic [M_MAX-1:0]  w_syn_tap  [c_nl];
  logic [M_MAX-1:0]  w_xb       [c_nl];
  logic [M_MAX-1:0]  w_x2b      [c_nl];
  logic [M_MAX-1:0]  w_xlam     [c_nl];
  logic [M_MAX-1:0]  w_lam_next [c_nl];
  logic [M_MAX-1:0]  w_b_next   [c_nl];
  logic [M_MAX-1:0]  w_delta;
  logic [M_MAX-1:0]  w_cap_mask;
  logic [1:0]        w_cap_fsel;
  logic              w_take;
  logic              w_last;
  logic [c_lw-1:0]   w_l_next;
  logic [c_lw-1:0]   w_t;
  logic [c_rw-1:0]   w_two_t;
  logic [c_rw-1:0]   w_r_next;

  assign busy       = (r_state != IDLE);
  assign w_cap_fsel = fsel_of(code);
  assign w_cap_mask = mask_of(w_cap_fsel);
  assign w_t        = (r_fsel == c_f10) ? c_lw'(T_MAX) : c_lw'(2);
  assign w_two_t    = (r_fsel == c_f10) ? c_rw'(c_ns)  : c_rw'(4);
  assign w_r_next   = r_r + c_rw'(2);
  assign w_last     = (w_r_next == w_two_t);

  // Discrepancy: sum of Lambda_i * S(r+1-i); taps outside S1..S2T read as 0.
  always_comb begin
    w_delta = {M_MAX{1'b0}};
    for (int i = 0; i < c_nl; i++) begin
      w_syn_tap[i] = {M_MAX{1'b0}};
      for (int k = 1; k <= c_ns; k++) begin
        if (int'(r_r) + 1 - i == k) w_syn_tap[i] = r_syn[k-1];
      end
      w_delta = w_delta ^ gf_mul(r_lam[i], w_syn_tap[i], r_fsel);
    end
  end

  // Shifted copies of B and Lambda, truncated at degree T_MAX.
  always_comb begin
    for (int i = 0; i < c_nl; i++) begin
      w_xb[i]   = {M_MAX{1'b0}};
      w_x2b[i]  = {M_MAX{1'b0}};
      w_xlam[i] = {M_MAX{1'b0}};
    end
    for (int i = 1; i < c_nl; i++) begin
      w_xb[i]   = r_b[i-1];
      w_xlam[i] = r_lam[i-1];
    end
    for (int i = 2; i < c_nl; i++) begin
      w_x2b[i]  = r_b[i-2];
    end
  end

  // Length change only when the discrepancy is nonzero and 2L <= r.
  assign w_take   = (r_delta != {M_MAX{1'b0}}) &&
                    (((c_rw+1)'(r_l) << 1) <= (c_rw+1)'(r_r));
  assign w_l_next = w_take ? c_lw'(r_r + c_rw'(1) - c_rw'(r_l)) : r_l;

  always_comb begin
    for (int i = 0; i < c_nl; i++) begin
      w_lam_next[i] = gf_mul(r_gamma, r_lam[i], r_fsel) ^ gf_mul(r_delta, w_xb[i], r_fsel);
      w_b_next[i]   = w_take ? w_xlam[i] : w_x2b[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = DISC;
      DISC:    w_state_next = UPD;
      UPD:     w_state_next = w_last ? DONE : DISC;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fsel  <= 2'd0;
      r_gamma <= {M_MAX{1'b0}};
      r_delta <= {M_MAX{1'b0}};
      r_l     <= {c_lw{1'b0}};
      r_r     <= {c_rw{1'b0}};
      for (int k = 0; k < c_ns; k++) r_syn[k] <= {M_MAX{1'b0}};
      for (int i = 0; i < c_nl; i++) begin
        r_lam[i] <= {M_MAX{1'b0}};
        r_b[i]   <= {M_MAX{1'b0}};
      end
      done   <= 1'b0;
      lambda <= '0;
      deg    <= 3'd0;
      fail   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_fsel <= w_cap_fsel;
            // Syndromes beyond S2t and bits above m are dropped here.
            for (int k = 0; k < c_ns; k++) begin
              r_syn[k] <= ((w_cap_fsel == c_f10) || (k < 4)) ?
                          (syn[k*M_MAX +: M_MAX] & w_cap_mask) : {M_MAX{1'b0}};
            end
            for (int i = 0; i < c_nl; i++) begin
              r_lam[i] <= (i == 0) ? M_MAX'(1) : {M_MAX{1'b0}};
              r_b[i]   <= (i == 0) ? M_MAX'(1) : {M_MAX{1'b0}};
            end
            r_gamma <= M_MAX'(1);
            r_l     <= {c_lw{1'b0}};
            r_r     <= {c_rw{1'b0}};
          end
        end
        DISC: r_delta <= w_delta;
        UPD: begin
          for (int i = 0; i < c_nl; i++) begin
            r_lam[i] <= w_lam_next[i];
            r_b[i]   <= w_b_next[i];
          end
          if (w_take) r_gamma <= r_delta;
          r_l <= w_l_next;
          r_r <= w_r_next;
          // Results are registered on entry to DONE so done is seen in DONE.
          if (w_last) begin
            done <= 1'b1;
            for (int i = 0; i < c_nl; i++) begin
              lambda[i*M_MAX +: M_MAX] <= (i <= int'(w_t)) ? w_lam_next[i] : {M_MAX{1'b0}};
            end
            deg  <= w_l_next;
            fail <= (w_l_next > w_t);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/bch_ibm_solver.md
Name: bch_ibm_solver

Overview:
- Inversion-free Berlekamp–Massey key-equation solver for the binary BCH decoder.
- Sits directly downstream of the syndrome stage and upstream of the Chien search.
- Takes 2t syndromes and produces the error-locator polynomial Λ(x), its degree L, and an uncorrectable flag.
- Supports the three decoder codes: (63,51) t=2 over GF(2^6), (255,239) t=2 over GF(2^8), (1023,983) t=4 over GF(2^10).

Parameters:
- M_MAX, 10, widest field size m; every field element is carried in an M_MAX-bit container.
- T_MAX, 4, maximum correction capability; sizes the syndrome and Λ buses.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- code  in  2  1: m=6,t=2; 2: m=8,t=2; 3 or 0: m=10,t=4. Sampled with start.
- start  in  1  single-cycle request. Accepted only in IDLE.
- syn  in  80  S1..S8 packed, 10 bits each. S1=[9:0], S8=[79:70]. Sampled with start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when results are valid.
- lambda  out  50  Λ0..Λ4 packed, 10 bits each. Λ0=[9:0].
- deg  out  3  final L.
- fail  out  1  1 when L>t at completion.

Behaviour:
- Reset: state=IDLE. busy=0, done=0, fail=0, deg=0, lambda=0. Internal Λ, B, γ, L, iteration counter all cleared.
- Field selection from latched code:
  - m=6: p(x)=x^6+x+1
  - m=8: p(x)=x^8+x^4+x^3+x^2+1
  - m=10: p(x)=x^10+x^3+1
- Input bits above m are masked to 0 at capture.
- Syndromes beyond S2t are ignored (t=2 uses S1..S4).
- All multipliers are combinational GF(2^m) multipliers, selected by latched m. Results above bit m-1 are always 0.
- Initialisation on start acceptance: Λ=1, B=1, γ=1, L=0, r=0. Syndromes and code are latched.
- FSM states: IDLE -> DISC -> UPD -> (DISC | DONE) -> IDLE.
- IDLE:
  - Waits for start; on start, latch inputs and go to DISC.
  - start in any other state is ignored.
- DISC (1 cycle):
  - δ = Σ_{i=0..4} Λi·S(r+1-i), with S(k)=0 for k<1.
  - Register δ.
- UPD (1 cycle), binary-simplified step covering iterations r and r+1:
  - Λ' = γ·Λ + δ·x·B, truncated to degree 4.
  - If δ≠0 and 2L≤r: B←x·Λ(old), L←r+1-L, γ←δ.
  - Else: B←x²·B; L and γ unchanged.
  - Then r←r+2.
  - If r==2t go to DONE, else go to DISC.
- DONE (1 cycle):
  - done=1; lambda, deg and fail registered.
  - fail=1 if L>t.
  - Go to IDLE.
- Outputs hold their values until the next DONE.
- Latency: start accepted at cycle 0, done at cycle 2t+1 (5 for t=2, 9 for t=4).
- Λ output is a nonzero scalar multiple of the monic locator. Roots are unchanged; downstream normalisation is not required.
- Coefficients above degree t are forced to 0 in the output.
- start coincident with done: ignored, since FSM is in DONE, not IDLE.
- A new start is accepted the cycle after done.
- Reset asserted mid-operation: immediate return to reset values; no done pulse.
- All-zero syndromes: δ=0 every step, giving Λ=1, L=0, fail=0.

Test Plan:
- code=1, syn all 0, start -> done at cycle 5; lambda Λ0=1, Λ1..Λ4=0; deg=0; fail=0.
- code=1, single error j=1 (S1=0x02, S2=0x04, S3=0x08, S4=0x10) -> Λ0=0x02, Λ1=0x04, others 0; deg=1; fail=0; done at cycle 5.
- code=3, single error j=0 (S1..S8=1) -> Λ0=1, Λ1=1, others 0; deg=1; done at cycle 9.
- code=2, two errors at positions 3 and 100 (syndromes from a reference model) -> deg=2; Λ(α^-3)=0 and Λ(α^-100)=0 in GF(2^8); fail=0.
- code=3, five-error syndromes from model -> deg>4 reported via fail=1 with done pulse; a second start one cycle after done is accepted.
- start pulsed while busy, then rstn low at cycle 3 -> busy=0, done never pulses, lambda=0; a fresh start after release completes normally.
